// File: rtl/press_window_sequencer.sv
// Seconds countdown and commit sequencer for the 2-second press detector.
// Owns the `count` window, settles the press tally and pulses `new_state` on commit.
module press_window_sequencer #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int WINDOW_S  = 3,
  parameter int COMMIT_S  = 2,
  parameter int NS_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        count_trigger_press,
  input  logic [1:0]  press_count_2bits,
  output logic [31:0] count,
  output logic        new_state,
  output logic [1:0]  mode,
  output logic        tick_1s
);

  localparam int PW = $clog2(CLK_HZ);
  localparam int SW = $clog2(COMMIT_S + 1);
  localparam int NW = $clog2(NS_CYCLES + 1);

  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [SW-1:0] SECS_LAST = SW'(COMMIT_S - 1);
  localparam logic [NW-1:0] NS_LAST   = NW'(NS_CYCLES - 1);
  localparam logic [31:0]   RELOAD    = 32'(WINDOW_S);

  typedef enum logic [1:0] {
    HOLD,
    WINDOW,
    SETTLE,
    PULSE
  } state_t;

  state_t state;
  state_t next_state;

  logic [PW-1:0] cd_presc;
  logic [PW-1:0] cm_presc;
  logic [SW-1:0] cm_secs;
  logic [NW-1:0] ns_cnt;
  logic [1:0]    prev_tally;

  logic tally_nz;
  logic tally_changed;
  logic cd_run;
  logic cd_wrap;
  logic cm_expire;
  logic cm_clear;
  logic ns_done;
  logic enter_pulse;

  assign tally_nz      = (press_count_2bits != 2'd0);
  assign tally_changed = (press_count_2bits != prev_tally);

  // The countdown prescaler only runs once the FSM has actually moved into
  // WINDOW, so the first decrement lands a full second after the trigger drop.
  assign cd_run      = (state == WINDOW) && !count_trigger_press;
  assign cd_wrap     = cd_run && (cd_presc == PRESC_MAX);
  assign cm_expire   = (cm_presc == PRESC_MAX) && (cm_secs == SECS_LAST);
  assign ns_done     = (ns_cnt == NS_LAST);
  assign enter_pulse = (state != PULSE) && (next_state == PULSE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HOLD;
    end else begin
      state <= next_state;
    end
  end

  // Trigger activity outranks tally activity, which outranks commit expiry.
  always_comb begin
    next_state = state;
    cm_clear   = 1'b1;
    case (state)
      HOLD: begin
        if (!count_trigger_press) begin
          next_state = WINDOW;
        end else if (tally_nz) begin
          next_state = SETTLE;
        end
      end
      WINDOW: begin
        if (count_trigger_press) begin
          next_state = tally_nz ? SETTLE : HOLD;
        end
      end
      SETTLE: begin
        if (!count_trigger_press) begin
          next_state = WINDOW;
        end else if (!tally_nz) begin
          next_state = HOLD;
        end else if (tally_changed) begin
          next_state = SETTLE;
        end else if (cm_expire) begin
          next_state = PULSE;
        end else begin
          cm_clear = 1'b0;
        end
      end
      PULSE: begin
        if (ns_done) begin
          next_state = HOLD;
        end
      end
      default: begin
        next_state = HOLD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cd_presc <= '0;
      tick_1s  <= 1'b0;
    end else begin
      tick_1s <= cd_wrap;
      if (!cd_run || cd_wrap) begin
        cd_presc <= '0;
      end else begin
        cd_presc <= cd_presc + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= RELOAD;
    end else if (count_trigger_press || (state == PULSE)) begin
      count <= RELOAD;
    end else if (cd_wrap && (count != 32'd0)) begin
      count <= count - 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cm_presc <= '0;
      cm_secs  <= '0;
    end else if (cm_clear) begin
      cm_presc <= '0;
      cm_secs  <= '0;
    end else if (cm_presc == PRESC_MAX) begin
      cm_presc <= '0;
      cm_secs  <= cm_secs + SW'(1);
    end else begin
      cm_presc <= cm_presc + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ns_cnt <= '0;
    end else if (state != PULSE) begin
      ns_cnt <= '0;
    end else begin
      ns_cnt <= ns_cnt + NW'(1);
    end
  end

  // new_state is registered so that reset clears it without waiting for an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      new_state  <= 1'b0;
      mode       <= 2'd0;
      prev_tally <= 2'd0;
    end else begin
      new_state  <= (next_state == PULSE);
      prev_tally <= press_count_2bits;
      if (enter_pulse) begin
        mode <= press_count_2bits;
      end
    end
  end

endmodule
